counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
// PURPOSE
//   Command-driven controller for a WIDTH-bit event/period counter.
//   Accepts start/stop/clear commands over a valid/ready handshake and runs
//   the counter from 0 up to a programmed limit, in one-shot or periodic mode.
//   Flags terminal count and completion. Sits between a control master and
//   the divider/counter chain as its sequencer.
// PARAMETERS
//   WIDTH  8  counter and limit width in bits (>=2)
// PORTS
//   clk        in   1      rising-edge clock; sole clock domain
//   reset      in   1      synchronous, active-high reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      block can accept a command
//   cmd_op     in   2      00 START_ONESHOT, 01 START_PERIODIC, 10 STOP, 11 CLEAR
//   cmd_limit  in   WIDTH  terminal value; sampled only with START ops
//   count      out  WIDTH  current counter value (registered)
//   busy       out  1      state == RUN
//   tc         out  1      terminal count: state==RUN && count==limit_q (combinational)
//   done       out  1      state == DONE (one-shot finished)
// BEHAVIOUR
//   Reset (sync, highest priority): state=IDLE, count=0, limit_q=0, mode_q=0,
//     pend=0. cmd_ready=0 while reset is high. busy=tc=done=0.
//   Handshake: cmd_ready = !reset && !pend. A command is accepted on an edge
//     where cmd_valid && cmd_ready. op/limit are latched into a one-deep
//     register and pend=1. pend clears on the next edge, when the command is
//     applied. So cmd_ready is low for exactly one cycle after each accept,
//     and back-to-back commands are accepted on every other cycle at most.
//     cmd_valid without cmd_ready is held off. No command is ever dropped.
//   FSM states: IDLE, RUN, DONE. Apply edge (pend=1):
//     START_*: count<=0, limit_q<=latched limit, mode_q<=op[0], state<=RUN.
//       Legal from any state; in RUN it retriggers.
//     STOP: state<=IDLE; count holds its value.
//     CLEAR: state<=IDLE, count<=0.
//   RUN edge with no apply:
//     count!=limit_q: count<=count+1.
//     count==limit_q, periodic: count<=0; stay in RUN.
//     count==limit_q, one-shot: state<=DONE; count holds at limit_q.
//   IDLE and DONE: count holds.
//   Period: limit_q+1 cycles per tc in periodic mode.
//   Latency: START accepted at edge N, count=0 and busy=1 after edge N+1,
//     first tc in the cycle after edge N+1+limit_q.
//   limit=0: tc is high in every RUN cycle. Periodic holds count at 0.
//     One-shot goes to DONE one edge after entering RUN.
//   limit=2^WIDTH-1: count never overflows, since the compare precedes the
//     increment. Periodic wrap to 0 is explicit.
//   Simultaneous apply and terminal count: the command wins. No RUN-rule
//     update that edge; tc may still be high in that cycle.
//   Reset mid-RUN or with pend=1: the pending command is discarded, IDLE next.
// TESTING
//   1 reset: hold reset 3 cycles -> count=0, busy=done=tc=0, cmd_ready=0
//     during reset, 1 after.
//   2 START_PERIODIC limit=3 -> count 0,1,2,3,0,1..; tc high every 4th cycle;
//     busy=1; done=0.
//   3 START_ONESHOT limit=5 -> count 0..5, tc high one cycle at 5, then
//     done=1, busy=0, count stays 5.
//   4 STOP at count=2 -> IDLE, count holds 2. Then CLEAR -> count=0.
//     cmd_ready low exactly 1 cycle after each accept.
//   5 limit=0 periodic -> tc constant 1, count 0. Limit=255 (WIDTH=8)
//     periodic -> 255 then 0, no X.
//   6 retrigger START limit=2 on the edge count==limit_q, and assert reset
//     with pend=1 -> command wins (count=0, RUN); reset discards pending, IDLE.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven one-shot/periodic counter sequencer with a one-deep command latch
module counter_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, limit_q, limit_d, plim_q, plim_d;
  logic [1:0]       op_q, op_d;
  logic             mode_q, mode_d, pend_q, pend_d, at_lim;
  assign cmd_ready = !reset && !pend_q;
  assign at_lim    = count_q == limit_q;
  assign count     = count_q;
  assign busy      = state_q == RUN;
  assign tc        = busy && at_lim;
  assign done      = state_q == DONE;
  // A latched command is applied one edge after acceptance and overrides the RUN update.
  always_comb begin
    pend_d  = cmd_valid && cmd_ready;
    op_d    = pend_d ? cmd_op : op_q;
    plim_d  = pend_d ? cmd_limit : plim_q;
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    if (pend_q) begin
      if (!op_q[1]) begin
        state_d = RUN;
        count_d = '0;
        limit_d = plim_q;
        mode_d  = op_q[0];
      end else begin
        state_d = IDLE;
        count_d = op_q[0] ? '0 : count_q;
      end
    end else if (state_q == RUN) begin
      if (!at_lim) count_d = count_q + WIDTH'(1);
      else if (mode_q) count_d = '0;
      else state_d = DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      limit_q <= '0;
      plim_q  <= '0;
      op_q    <= '0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      plim_q  <= plim_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
    end
  end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: randomized self-checking bench against an elapsed-time reference model
module tb_counter_sequencer;
  logic       clk = 0, reset = 1, cmd_valid = 0;
  logic [1:0] cmd_op = 0;
  logic [7:0] cmd_limit = 0;
  logic       cmd_ready, busy, tc, done;
  logic [7:0] count;
  int ncmp = 0, nerr = 0;
  counter_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_limit(cmd_limit), .count(count),
    .busy(busy), .tc(tc), .done(done)
  );
  always #5 clk = ~clk;
  // Model: after a START, the count is a function of cycles elapsed since it took effect.
  bit m_started = 0, m_per = 0, m_pv = 0;
  int m_t = 0, m_lim = 0, m_hold = 0, m_plim = 0;
  logic [1:0] m_pop = 0;
  function automatic int e_cnt();
    if (!m_started) return m_hold;
    if (m_per) return m_t % (m_lim + 1);
    return (m_t > m_lim) ? m_lim : m_t;
  endfunction
  function automatic bit e_busy();
    return m_started && (m_per || m_t <= m_lim);
  endfunction
  function automatic logic [3:0] e_stat();
    bit b = e_busy();
    return {b, b && e_cnt() == m_lim, m_started && !m_per && m_t > m_lim, !reset && !m_pv};
  endfunction
  task automatic tick();
    bit acc = !reset && !m_pv && cmd_valid;
    logic [1:0] op = cmd_op;
    int lim = cmd_limit;
    @(posedge clk);
    if (reset) begin
      m_started = 0; m_hold = 0; m_lim = 0; m_pv = 0; m_per = 0;
    end else begin
      if (m_pv) begin
        if (!m_pop[1]) begin
          m_started = 1; m_t = 0; m_lim = m_plim; m_per = m_pop[0];
        end else begin
          m_hold = m_pop[0] ? 0 : e_cnt();
          m_started = 0;
        end
      end else if (m_started) m_t++;
      m_pv = acc;
      if (acc) begin m_pop = op; m_plim = lim; end
    end
    #1;
  endtask
  task automatic send(input logic [1:0] op, input logic [7:0] lim);
    int n = 0;
    cmd_valid = 1; cmd_op = op; cmd_limit = lim;
    while ((reset || m_pv) && n < 10) begin tick(); n++; end
    tick();
    cmd_valid = 0; cmd_limit = 8'($urandom);
  endtask
  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ncmp += 2;
      if (count !== 8'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", count); end
      if ({busy, tc, done, cmd_ready} !== 4'b0000) begin
        nerr++; $display("FAIL reset_status: got %b want 0000", {busy, tc, done, cmd_ready});
      end
    end
    reset = 0; #1;
    ncmp++;
    if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready_after: got %b want 1", cmd_ready); end
  endtask
  task automatic test_periodic();
    int ntc = 0;
    send(2'b01, 8'd3);
    tick();
    for (int i = 0; i < 12; i++) begin
      ncmp += 2;
      if (count !== 8'(e_cnt())) begin nerr++; $display("FAIL periodic_count: got %0d want %0d", count, e_cnt()); end
      if ({busy, tc, done, cmd_ready} !== e_stat()) begin
        nerr++; $display("FAIL periodic_status: got %b want %b", {busy, tc, done, cmd_ready}, e_stat());
      end
      ntc += tc;
      tick();
    end
    ncmp++;
    if (ntc !== 3) begin nerr++; $display("FAIL periodic_tc_rate: got %0d want 3", ntc); end
  endtask
  task automatic test_oneshot();
    send(2'b00, 8'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      ncmp += 2;
      if (count !== 8'(e_cnt())) begin nerr++; $display("FAIL oneshot_count: got %0d want %0d", count, e_cnt()); end
      if ({busy, tc, done, cmd_ready} !== e_stat()) begin
        nerr++; $display("FAIL oneshot_status: got %b want %b", {busy, tc, done, cmd_ready}, e_stat());
      end
    end
    ncmp++;
    if ({count, busy, done} !== {8'd5, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL oneshot_final: got count=%0d busy=%b done=%b want 5/0/1", count, busy, done);
    end
  endtask
  task automatic test_stop_clear();
    int n = 0;
    send(2'b01, 8'd7);
    while (e_cnt() != 1 && n < 20) begin tick(); n++; end
    send(2'b10, 8'd0);
    ncmp++;
    if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL stop_ready_low: got %b want 0", cmd_ready); end
    tick();
    ncmp += 2;
    if (count !== 8'd2) begin nerr++; $display("FAIL stop_hold: got %0d want 2", count); end
    if ({busy, tc, done, cmd_ready} !== 4'b0001) begin
      nerr++; $display("FAIL stop_status: got %b want 0001", {busy, tc, done, cmd_ready});
    end
    tick();
    send(2'b11, 8'd0);
    ncmp++;
    if (cmd_ready !== 1'b0) begin nerr++; $display("FAIL clear_ready_low: got %b want 0", cmd_ready); end
    tick();
    ncmp += 2;
    if (count !== 8'd0) begin nerr++; $display("FAIL clear_count: got %0d want 0", count); end
    if ({busy, tc, done, cmd_ready} !== 4'b0001) begin
      nerr++; $display("FAIL clear_status: got %b want 0001", {busy, tc, done, cmd_ready});
    end
  endtask
  task automatic test_limits();
    bit seen_wrap = 0;
    send(2'b01, 8'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      ncmp++;
      if ({count, tc, busy} !== {8'd0, 1'b1, 1'b1}) begin
        nerr++; $display("FAIL limit0: got count=%0d tc=%b busy=%b want 0/1/1", count, tc, busy);
      end
      tick();
    end
    send(2'b01, 8'd255);
    for (int i = 0; i < 262; i++) begin
      tick();
      if (count === 8'd0 && e_cnt() == 0 && m_t == 256) seen_wrap = 1;
      ncmp += 2;
      if (count !== 8'(e_cnt())) begin nerr++; $display("FAIL limit255_count: got %0d want %0d", count, e_cnt()); end
      if ({busy, tc, done, cmd_ready} !== e_stat()) begin
        nerr++; $display("FAIL limit255_status: got %b want %b", {busy, tc, done, cmd_ready}, e_stat());
      end
    end
    ncmp++;
    if (!seen_wrap) begin nerr++; $display("FAIL limit255_wrap: got no wrap want wrap to 0"); end
  endtask
  task automatic test_retrigger_reset();
    int n = 0;
    send(2'b01, 8'd4);
    while (e_cnt() != 3 && n < 20) begin tick(); n++; end
    send(2'b00, 8'd2);
    ncmp++;
    if ({count, tc} !== {8'd4, 1'b1}) begin
      nerr++; $display("FAIL retrig_at_tc: got count=%0d tc=%b want 4/1", count, tc);
    end
    tick();
    ncmp += 2;
    if ({count, busy} !== {8'd0, 1'b1}) begin
      nerr++; $display("FAIL retrig_apply: got count=%0d busy=%b want 0/1", count, busy);
    end
    if ({busy, tc, done, cmd_ready} !== e_stat()) begin
      nerr++; $display("FAIL retrig_status: got %b want %b", {busy, tc, done, cmd_ready}, e_stat());
    end
    send(2'b01, 8'd6);
    reset = 1;
    tick();
    reset = 0;
    tick();
    tick();
    ncmp++;
    if ({count, busy, done, cmd_ready} !== {8'd0, 3'b001}) begin
      nerr++; $display("FAIL reset_pending: got count=%0d busy=%b done=%b rdy=%b want 0/0/0/1",
                       count, busy, done, cmd_ready);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      cmd_valid = $urandom_range(0, 3) == 0;
      cmd_op = 2'($urandom);
      cmd_limit = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      tick();
      ncmp += 2;
      if (count !== 8'(e_cnt())) begin nerr++; $display("FAIL random_count: got %0d want %0d", count, e_cnt()); end
      if ({busy, tc, done, cmd_ready} !== e_stat()) begin
        nerr++; $display("FAIL random_status: got %b want %b", {busy, tc, done, cmd_ready}, e_stat());
      end
    end
    reset = 0; cmd_valid = 0;
  endtask
  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_stop_clear();
    test_limits();
    test_retrigger_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
